// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: MEM-over-IF fixed-priority arbiter for one external SRAM, with LB extract and SB lane steering.
// Optional MEM_ARB_ALIGN_EXC_EN: misaligned word accesses complete at once with mem_addr_err instead of an SRAM cycle.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic [3:0]        mem_mode,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic              mem_addr_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  // IO mode codes, mirroring the pipeline's shared defines
  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LB  = 4'd1;
  localparam logic [3:0] IO_LW  = 4'd2;
  localparam logic [3:0] IO_SB  = 4'd3;
  localparam logic [3:0] IO_SW  = 4'd4;
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_is_mem, w_is_mem_nxt;
  logic              r_rd, w_rd_nxt;
  logic              r_byte, w_byte_nxt;
  logic [1:0]        r_lane, w_lane_nxt;
  logic [ADDR_W-1:0] r_sram_addr, w_addr_nxt;
  logic [31:0]       r_sram_wdata, w_wdata_nxt;
  logic [3:0]        r_sram_be_n, w_be_n_nxt;
  logic              r_ce_n, w_ce_n_nxt;
  logic              r_oe_n, w_oe_n_nxt;
  logic              r_we_n, w_we_n_nxt;
  logic [31:0]       r_if_rdata, w_if_rdata_nxt;
  logic [31:0]       r_mem_rdata, w_mem_rdata_nxt;
  logic              r_if_done, w_if_done_nxt;
  logic              r_mem_done, w_mem_done_nxt;
  logic              r_addr_err, w_addr_err_nxt;

  logic              w_mem_req;
  logic              w_mem_wr;
  logic              w_mem_byte;
  logic              w_misalign;
  logic [7:0]        w_rd_byte;
  logic [31:0]       w_load_data;
  logic              w_unused_bits;

  // Unknown non-NOP codes are still requests; they behave as word reads
  assign w_mem_req  = (mem_mode != IO_NOP);
  assign w_mem_wr   = (mem_mode == IO_SB) || (mem_mode == IO_SW);
  assign w_mem_byte = (mem_mode == IO_LB) || (mem_mode == IO_SB);

`ifdef MEM_ARB_ALIGN_EXC_EN
  assign w_misalign   = w_mem_req ? (~w_mem_byte & (|mem_addr[1:0])) : (|if_addr[1:0]);
  assign mem_addr_err = r_addr_err;
`else
  assign w_misalign   = 1'b0;
  assign mem_addr_err = 1'b0;
`endif

  assign w_unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], r_addr_err};

  always_comb begin
    w_rd_byte = sram_rdata[7:0];
    case (r_lane)
      2'd0:    w_rd_byte = sram_rdata[7:0];
      2'd1:    w_rd_byte = sram_rdata[15:8];
      2'd2:    w_rd_byte = sram_rdata[23:16];
      2'd3:    w_rd_byte = sram_rdata[31:24];
      default: w_rd_byte = sram_rdata[7:0];
    endcase
  end

  assign w_load_data = r_byte ? {{24{w_rd_byte[7]}}, w_rd_byte} : sram_rdata;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_is_mem_nxt    = r_is_mem;
    w_rd_nxt        = r_rd;
    w_byte_nxt      = r_byte;
    w_lane_nxt      = r_lane;
    w_addr_nxt      = r_sram_addr;
    w_wdata_nxt     = r_sram_wdata;
    w_be_n_nxt      = r_sram_be_n;
    w_ce_n_nxt      = r_ce_n;
    w_oe_n_nxt      = r_oe_n;
    w_we_n_nxt      = r_we_n;
    w_if_rdata_nxt  = r_if_rdata;
    w_mem_rdata_nxt = r_mem_rdata;
    w_if_done_nxt   = 1'b0;
    w_mem_done_nxt  = 1'b0;
    w_addr_err_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_mem_req || if_req) begin
          w_is_mem_nxt = w_mem_req;
          w_rd_nxt     = ~(w_mem_req & w_mem_wr);
          w_byte_nxt   = w_mem_req & w_mem_byte;
          w_lane_nxt   = w_mem_req ? mem_addr[1:0] : 2'b00;
          if (w_misalign) begin
            // Trapped access: no SRAM cycle, straight to the completion pulse
            w_state_nxt    = S_DONE;
            w_mem_done_nxt = w_mem_req;
            w_addr_err_nxt = w_mem_req;
            w_if_done_nxt  = ~w_mem_req;
            if (!w_mem_req) begin
              w_if_rdata_nxt = 32'd0;
            end
          end else begin
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = C_WAIT;
            w_ce_n_nxt  = 1'b0;
            w_addr_nxt  = w_mem_req ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
            if (w_mem_req && w_mem_wr) begin
              w_we_n_nxt  = 1'b0;
              w_be_n_nxt  = w_mem_byte ? ~(4'b0001 << mem_addr[1:0]) : 4'b0000;
              w_wdata_nxt = w_mem_byte ? {4{mem_wdata[7:0]}} : mem_wdata;
            end else begin
              w_oe_n_nxt = 1'b0;
              w_be_n_nxt = 4'b0000;
            end
          end
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
          w_ce_n_nxt  = 1'b1;
          w_oe_n_nxt  = 1'b1;
          w_we_n_nxt  = 1'b1;
          w_be_n_nxt  = 4'b1111;
          if (r_is_mem) begin
            w_mem_done_nxt = 1'b1;
            if (r_rd) begin
              w_mem_rdata_nxt = w_load_data;
            end
          end else begin
            w_if_done_nxt  = 1'b1;
            w_if_rdata_nxt = sram_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_is_mem     <= 1'b0;
      r_rd         <= 1'b0;
      r_byte       <= 1'b0;
      r_lane       <= 2'b00;
      r_sram_addr  <= '0;
      r_sram_wdata <= 32'd0;
      r_sram_be_n  <= 4'b1111;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_if_rdata   <= 32'd0;
      r_mem_rdata  <= 32'd0;
      r_if_done    <= 1'b0;
      r_mem_done   <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_is_mem     <= w_is_mem_nxt;
      r_rd         <= w_rd_nxt;
      r_byte       <= w_byte_nxt;
      r_lane       <= w_lane_nxt;
      r_sram_addr  <= w_addr_nxt;
      r_sram_wdata <= w_wdata_nxt;
      r_sram_be_n  <= w_be_n_nxt;
      r_ce_n       <= w_ce_n_nxt;
      r_oe_n       <= w_oe_n_nxt;
      r_we_n       <= w_we_n_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_mem_rdata  <= w_mem_rdata_nxt;
      r_if_done    <= w_if_done_nxt;
      r_mem_done   <= w_mem_done_nxt;
      r_addr_err   <= w_addr_err_nxt;
    end
  end

  assign if_rdata   = r_if_rdata;
  assign if_done    = r_if_done;
  assign if_stall   = if_req & ~r_if_done;
  assign mem_rdata  = r_mem_rdata;
  assign mem_done   = r_mem_done;
  assign mem_stall  = w_mem_req & ~r_mem_done;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_be_n  = r_sram_be_n;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed + random stimulus against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int W = 1;
  localparam logic [3:0] IO_NOP = 4'd0, IO_LB = 4'd1, IO_LW = 4'd2, IO_SB = 4'd3, IO_SW = 4'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_done, if_stall;
  logic [3:0]  mem_mode = IO_NOP;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_stall, mem_addr_err;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_stall(mem_stall), .mem_addr_err(mem_addr_err),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_be_n(sram_be_n),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Pin-level SRAM (16 words, aliased)
  logic [31:0] sram_mem [16];
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[3:0]] : 32'h0BAD_F00D;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[3:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding access, timed by grant cycle
  logic [31:0] m_ref [16];
  logic [3:0]  be_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  bit          m_act, m_is_mem, m_mis;
  int          m_g, m_done_cyc;
  logic [3:0]  m_mode;
  logic [31:0] m_addr, m_wdata;
  logic [19:0] e_addr;
  logic [31:0] e_wdata, e_if_rdata, e_mem_rdata, bv;
  logic [3:0]  e_be;
  bit          e_ce, e_oe, e_we, e_if_done, e_mem_done, e_err, in_acc, dn, wr, byt, mis;
  int          sv, lane, idx;
  bit          last_if_done, last_mem_done;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      m_act = 0; e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_mem_rdata = 0;
      e_ce = 1; e_oe = 1; e_we = 1; e_be = 4'hF; e_if_done = 0; e_mem_done = 0; e_err = 0;
    end else begin
      in_acc = m_act && !m_mis && (cyc >= m_g + 1) && (cyc <= m_g + W + 1);
      dn     = m_act && (cyc == m_done_cyc);
      wr     = m_is_mem && (m_mode == IO_SB || m_mode == IO_SW);
      byt    = m_is_mem && (m_mode == IO_SB || m_mode == IO_LB);
      lane   = int'(m_addr[1:0]);
      idx    = int'(m_addr[5:2]);
      if (in_acc && cyc == m_g + 1) begin
        e_addr = m_addr[21:2];
        if (wr) e_wdata = byt ? {24'd0, m_wdata[7:0]} * 32'h0101_0101 : m_wdata;
      end
      e_ce = !in_acc;
      e_oe = !(in_acc && !wr);
      e_we = !(in_acc && wr);
      e_be = !in_acc ? 4'hF : ((wr && byt) ? be_tbl[lane] : 4'h0);
      e_if_done  = dn && !m_is_mem;
      e_mem_done = dn && m_is_mem;
      e_err      = dn && m_is_mem && m_mis;
      if (dn && !m_is_mem) e_if_rdata = m_mis ? 32'd0 : m_ref[idx];
      if (dn && m_is_mem && !m_mis) begin
        if (m_mode == IO_SW) m_ref[idx] = m_wdata;
        else if (m_mode == IO_SB)
          m_ref[idx] = (m_ref[idx] & ~(32'hFF << (8*lane))) | ({24'd0, m_wdata[7:0]} << (8*lane));
        else if (m_mode == IO_LB) begin
          bv = (m_ref[idx] >> (8*lane)) & 32'hFF;
          sv = (bv >= 128) ? int'(bv) - 256 : int'(bv);
          e_mem_rdata = 32'(sv);
        end else e_mem_rdata = m_ref[idx];
      end
    end
    chk("sram_ce_n", sram_ce_n, e_ce);
    chk("sram_oe_n", sram_oe_n, e_oe);
    chk("sram_we_n", sram_we_n, e_we);
    chk("sram_be_n", sram_be_n, e_be);
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_wdata", sram_wdata, e_wdata);
    chk("if_done", if_done, e_if_done);
    chk("mem_done", mem_done, e_mem_done);
    chk("mem_addr_err", mem_addr_err, e_err);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("mem_rdata", mem_rdata, e_mem_rdata);
    chk("if_stall", if_stall, if_req && !e_if_done);
    chk("mem_stall", mem_stall, (mem_mode != IO_NOP) && !e_mem_done);
    last_if_done  = e_if_done;
    last_mem_done = e_mem_done;
    if (rst_n && (!m_act || cyc > m_done_cyc)) begin
      if (mem_mode != IO_NOP || if_req) begin
`ifdef MEM_ARB_ALIGN_EXC_EN
        mis = (mem_mode != IO_NOP) ? ((mem_mode == IO_LW || mem_mode == IO_SW) && mem_addr[1:0] != 2'b00)
                                   : (if_addr[1:0] != 2'b00);
`else
        mis = 0;
`endif
        m_act    = 1;
        m_is_mem = (mem_mode != IO_NOP);
        m_mode   = mem_mode;
        m_addr   = m_is_mem ? mem_addr : if_addr;
        m_wdata  = mem_wdata;
        m_mis    = mis;
        m_g      = cyc;
        m_done_cyc = mis ? cyc + 1 : cyc + W + 2;
      end else m_act = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lb(input logic [31:0] a, input logic [31:0] exp);
    next_cycle(); mem_mode = IO_LB; mem_addr = a;
    repeat (W + 2) next_cycle();
    #2;
    chk("lb_done", mem_done, 1'b1);
    chk("lb_rdata", mem_rdata, exp);
    next_cycle(); mem_mode = IO_NOP;
  endtask

  function automatic bit if_granted();
    return m_act && !m_is_mem && cyc <= m_done_cyc;
  endfunction
  function automatic bit mem_granted();
    return m_act && m_is_mem && cyc <= m_done_cyc;
  endfunction

  bit if_busy = 0, mem_busy = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = $urandom;
      m_ref[i] = sram_mem[i];
    end
    repeat (3) next_cycle();
    #2;
    chk("rst_ce_n", sram_ce_n, 1'b1);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_if_rdata", if_rdata, 32'd0);
    next_cycle(); rst_n = 1'b1;

    // IF fetch: strobes low cycles 1-2, done cycle 3
    sram_mem[0] = 32'h3C01_1234; m_ref[0] = 32'h3C01_1234;
    next_cycle(); if_req = 1'b1; if_addr = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); #2;
      if (k < 3) begin
        chk("fetch_ce_n", sram_ce_n, 1'b0);
        chk("fetch_oe_n", sram_oe_n, 1'b0);
      end else begin
        chk("fetch_done", if_done, 1'b1);
        chk("fetch_rdata", if_rdata, 32'h3C01_1234);
      end
    end
    next_cycle(); if_req = 1'b0;

    // IF dropped after grant still completes
    next_cycle(); if_req = 1'b1; if_addr = 32'h4;
    next_cycle();
    next_cycle(); if_req = 1'b0;
    next_cycle(); #2;
    chk("drop_done", if_done, 1'b1);
    next_cycle();

    // LB sign extension
    sram_mem[2] = 32'h80FF_7F01; m_ref[2] = 32'h80FF_7F01;
    do_lb(32'hA, 32'hFFFF_FFFF);
    do_lb(32'h9, 32'h0000_007F);
    do_lb(32'hB, 32'hFFFF_FF80);

    // Contention: MEM first, IF granted after the recovery cycle
    sram_mem[1] = 32'h1111_2222; m_ref[1] = 32'h1111_2222;
    next_cycle(); if_req = 1'b1; if_addr = 32'h4; mem_mode = IO_LW; mem_addr = 32'h8;
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      if (k == 4) mem_mode = IO_NOP;
      #2;
      if (k == 3) begin
        chk("cont_mem_done", mem_done, 1'b1);
        chk("cont_mem_rdata", mem_rdata, 32'h80FF_7F01);
        chk("cont_if_stall3", if_stall, 1'b1);
      end
      if (k == 4) chk("cont_idle_ce", sram_ce_n, 1'b1);
      if (k == 6) chk("cont_if_stall6", if_stall, 1'b1);
      if (k == 7) begin
        chk("cont_if_done", if_done, 1'b1);
        chk("cont_if_rdata", if_rdata, 32'h1111_2222);
      end
    end
    next_cycle(); if_req = 1'b0;

    // SB lane steering
    next_cycle(); mem_mode = IO_SB; mem_addr = 32'h103; mem_wdata = 32'h0000_00AB;
    next_cycle(); #2;
    chk("sb_be_n", sram_be_n, 4'b0111);
    chk("sb_wdata", sram_wdata, 32'hABAB_ABAB);
    chk("sb_addr", sram_addr, 20'h40);
    chk("sb_we1", sram_we_n, 1'b0);
    next_cycle(); #2; chk("sb_we2", sram_we_n, 1'b0);
    next_cycle(); #2; chk("sb_we3", sram_we_n, 1'b1);
    next_cycle(); mem_mode = IO_NOP;

    // SW at misaligned address
    next_cycle(); mem_mode = IO_SW; mem_addr = 32'h102; mem_wdata = 32'h1234_5678;
    next_cycle(); #2;
`ifdef MEM_ARB_ALIGN_EXC_EN
    chk("swx_we", sram_we_n, 1'b1);
    chk("swx_done", mem_done, 1'b1);
    chk("swx_err", mem_addr_err, 1'b1);
`else
    chk("sw_we", sram_we_n, 1'b0);
    chk("sw_addr", sram_addr, 20'h40);
    next_cycle(); next_cycle(); #2;
    chk("sw_done", mem_done, 1'b1);
    chk("sw_err", mem_addr_err, 1'b0);
`endif
    next_cycle(); mem_mode = IO_NOP;

    // Reset mid-access, then quiet idle
    next_cycle(); if_req = 1'b1; if_addr = 32'h8;
    next_cycle();
    next_cycle(); rst_n = 1'b0; if_req = 1'b0;
    #2;
    chk("rstmid_ce_n", sram_ce_n, 1'b1);
    chk("rstmid_oe_n", sram_oe_n, 1'b1);
    next_cycle();
    next_cycle(); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next_cycle(); #2;
      chk("idle_ce_n", sram_ce_n, 1'b1);
      chk("idle_done", if_done | mem_done, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      if (if_busy && last_if_done) begin
        if_busy = 0; if_req = 1'b0;
      end else if (if_busy && if_granted()) begin
        if (if_req && $urandom_range(0, 15) == 0) if_req = 1'b0;
        else if ($urandom_range(0, 3) == 0) if_addr = $urandom;
      end
      if (!if_busy && $urandom_range(0, 2) == 0) begin
        if_busy = 1; if_req = 1'b1;
        if_addr = (($urandom & 32'h3F) & ~32'h3) | (($urandom & 32'h3) << 12);
        if ($urandom_range(0, 7) == 0) if_addr[1:0] = 2'($urandom_range(1, 3));
      end
      if (mem_busy && last_mem_done) begin
        mem_busy = 0; mem_mode = IO_NOP;
      end else if (mem_busy && mem_granted()) begin
        if (mem_mode != IO_NOP && $urandom_range(0, 15) == 0) mem_mode = IO_NOP;
        else if ($urandom_range(0, 3) == 0) begin
          mem_mode = 4'($urandom_range(1, 4)); mem_addr = $urandom; mem_wdata = $urandom;
        end
      end
      if (!mem_busy && $urandom_range(0, 2) == 0) begin
        mem_busy = 1;
        mem_mode = 4'($urandom_range(1, 4));
        mem_addr = ($urandom & 32'h3F) | (($urandom & 32'h3) << 12) | (32'($urandom_range(0, 1)) << 30);
        mem_wdata = $urandom;
      end
    end
    next_cycle(); if_req = 1'b0; mem_mode = IO_NOP;
    repeat (W + 4) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single external SRAM between instruction fetch (IF) and the load/store stage (MEM) of the MIPS32 pipeline.
- Runs a multi-cycle SRAM access FSM and performs LB byte extract/sign-extend and SB byte-lane steering.
- Produces per-requester done pulses and stall signals for the pipeline controller.
- Sits between the IF/MEM stages and the top-level SRAM pins.

Parameters:
- WAIT_CYCLES, 1, extra SRAM access cycles; an access phase lasts WAIT_CYCLES+1 cycles; legal range 0..15.
- ADDR_W, 20, SRAM word-address width; sram_addr = byte_addr[ADDR_W+1:2].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address; word aligned
- if_rdata  out  32  fetched word; valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_done
- mem_mode  in  4  IO_NOP/IO_LB/IO_LW/IO_SB/IO_SW from shared defines; any non-NOP code is a request, held until mem_done
- mem_addr  in  32  load/store byte address
- mem_wdata  in  32  store data; SB uses [7:0]
- mem_rdata  out  32  load result; valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse
- mem_stall  out  1  (mem_mode!=IO_NOP) & ~mem_done
- mem_addr_err  out  1  misaligned-access error, pulses with mem_done (see Optional Feature)
- sram_addr  out  ADDR_W  word address
- sram_wdata  out  32  write data
- sram_rdata  in  32  read data
- sram_be_n  out  4  byte enables, active low
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Reset and any assertion of rst_n=0, including mid-access, force IDLE immediately.
- Reset values: strobes and sram_be_n all 1; sram_addr, sram_wdata, counter, if_rdata, mem_rdata = 0; done pulses and mem_addr_err = 0.
- IDLE: on each clock edge, if a MEM request is present, latch the MEM request and go to ACCESS. Else, if if_req=1, latch the IF request and go to ACCESS. Else stay in IDLE.
- Priority is fixed: MEM over IF, because MEM holds the older instruction. A losing requester simply waits; its stall stays high.
- ACCESS: registered outputs sram_ce_n=0 and sram_addr = latched address, held for WAIT_CYCLES+1 cycles; a down-counter tracks the cycles.
  - Reads: sram_oe_n=0, sram_be_n=0000.
  - LW/SW: sram_be_n=0000.
  - SB: byte lane = addr[1:0], little-endian; only that sram_be_n bit is 0; sram_wdata = {4{mem_wdata[7:0]}}.
  - SW: sram_wdata = mem_wdata, sram_we_n=0.
  - On the last ACCESS cycle, read data is registered and the FSM moves to DONE.
- Read results:
  - LW returns the word unchanged.
  - LB returns byte lane addr[1:0] sign-extended to 32 bits.
  - IF returns the word to if_rdata.
- DONE: all strobes return to 1 and the requester's done pulse is high for exactly this cycle. The next state is always IDLE, so there are no back-to-back grants and there is always at least one idle (recovery) cycle between accesses.
- Latency: a request first seen at edge N (FSM in IDLE) gives done high in cycle N+WAIT_CYCLES+2. For WAIT_CYCLES=1 that is 3 cycles after the request.
- A request dropped during ACCESS is not aborted: the access completes and done still pulses.
- The latched request is unaffected by changes on request inputs after grant.
- if_rdata and mem_rdata hold their last value outside done.
- if_stall and mem_stall are combinational from current inputs and done.

Optional Feature:
- Macro: MEM_ARB_ALIGN_EXC_EN.
- When defined: an LW/SW with mem_addr[1:0]!=0, or an IF request with if_addr[1:0]!=0, is granted but starts no SRAM cycle (strobes stay 1). The FSM goes IDLE→DONE directly. The done pulse arrives 1 cycle after grant, with mem_addr_err=1 for MEM requests and if_rdata=0 for IF requests.
- When undefined: mem_addr_err is tied to 0, and address bits [1:0] are ignored for word accesses.

Test Plan:
- Reset + idle: rst_n=0 mid-ACCESS → within the same cycle strobes=1, state IDLE; after release with no requests, nothing toggles for 10 cycles.
- IF fetch, WAIT_CYCLES=1: sram_rdata=0x3C01_1234, if_req at cycle 0 → ce_n/oe_n low in cycles 1-2, if_done and if_rdata=0x3C011234 in cycle 3.
- Contention: if_req and mem_mode=IO_LW both at cycle 0 → MEM served first (mem_done cycle 3), IF granted at cycle 4, if_done cycle 7; if_stall high cycles 0-6.
- LB sign extension: memory word 0x80FF_7F01, addr lane 2 → mem_rdata=0xFFFF_FFFF; lane 1 → 0x0000_007F; lane 3 → 0xFFFF_FF80.
- SB: mem_addr=0x103, mem_wdata=0x0000_00AB → sram_be_n=0111, sram_wdata=0xABAB_ABAB, sram_addr=0x40, we_n low for 2 cycles.
- With MEM_ARB_ALIGN_EXC_EN: IO_SW at mem_addr=0x102 → no we_n pulse, mem_done + mem_addr_err=1 one cycle after grant; without the macro → a normal write occurs at word address 0x40.
